// File: rtl/snn_pkg.sv
// Steering command encoding shared with the motor controller,
// plus the output-buffer state type of the rate decoder.
package snn_pkg;

    localparam logic [1:0] DIR_STOP  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_FWD   = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sat_spike_counter.sv
// Saturating spike counter; o_cnt_nxt exposes the value including
// this cycle's spike so the window snapshot can count the final cycle.
module sat_spike_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_nxt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat     = (r_cnt == {CNT_W{1'b1}});
    assign o_cnt_nxt = (i_inc && !w_sat) ? r_cnt + CNT_W'(1) : r_cnt;
    assign o_cnt     = r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate-decodes the two output-layer spikes over fixed en-qualified
// windows and hands a steering command to the motor controller.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WIN_LEN    = 256,
    parameter int CNT_W      = 8,
    parameter int MARGIN     = 2,
    parameter int MIN_SPIKES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       spike_in,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [1:0]       cmd_dir,
    output logic [CNT_W-1:0] cmd_cnt_l,
    output logic [CNT_W-1:0] cmd_cnt_r,
    output logic             overrun
);

    localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    // Two guard bits so sums and margin offsets never wrap
    localparam int DW    = CNT_W + 2;

    logic [WIN_W-1:0] r_win_cnt;
    logic             w_win_end;

    logic [CNT_W-1:0] w_cnt_l;
    logic [CNT_W-1:0] w_cnt_r;
    logic [CNT_W-1:0] w_nxt_l;
    logic [CNT_W-1:0] w_nxt_r;

    logic [DW-1:0]    w_l;
    logic [DW-1:0]    w_r;
    logic [DW-1:0]    w_sum;
    logic [1:0]       w_dir;

    out_state_e       r_state;
    out_state_e       w_state_nxt;
    logic             w_load;
    logic             w_drop;
    logic             w_xfer;

    logic [1:0]       r_dir;
    logic [CNT_W-1:0] r_cnt_l;
    logic [CNT_W-1:0] r_cnt_r;
    logic             r_overrun;

    assign w_win_end = en && (r_win_cnt == WIN_W'(WIN_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_win_cnt <= '0;
        end else if (w_win_end) begin
            r_win_cnt <= '0;
        end else if (en) begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
    end

    sat_spike_counter #(.CNT_W(CNT_W)) u_cnt_l (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_win_end),
        .i_inc     (en && spike_in[0]),
        .o_cnt     (w_cnt_l),
        .o_cnt_nxt (w_nxt_l)
    );

    sat_spike_counter #(.CNT_W(CNT_W)) u_cnt_r (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_win_end),
        .i_inc     (en && spike_in[1]),
        .o_cnt     (w_cnt_r),
        .o_cnt_nxt (w_nxt_r)
    );

    assign w_l   = DW'(w_nxt_l);
    assign w_r   = DW'(w_nxt_r);
    assign w_sum = w_l + w_r;

    always_comb begin
        w_dir = DIR_FWD;
        if (w_sum < DW'(MIN_SPIKES)) begin
            w_dir = DIR_STOP;
        end else if (w_l >= w_r + DW'(MARGIN)) begin
            w_dir = DIR_LEFT;
        end else if (w_r >= w_l + DW'(MARGIN)) begin
            w_dir = DIR_RIGHT;
        end
    end

    assign w_xfer = (r_state == ST_FULL) && cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_win_end) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_win_end && w_xfer) begin
                    w_load = 1'b1;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_win_end) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_EMPTY;
            r_dir     <= DIR_STOP;
            r_cnt_l   <= '0;
            r_cnt_r   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= w_drop;
            if (w_load) begin
                r_dir   <= w_dir;
                r_cnt_l <= w_nxt_l;
                r_cnt_r <= w_nxt_r;
            end
        end
    end

    // Live counts are only consumed through the *_nxt snapshot path
    logic w_unused;
    assign w_unused = ^{w_cnt_l, w_cnt_r};

    assign cmd_valid = (r_state == ST_FULL);
    assign cmd_dir   = r_dir;
    assign cmd_cnt_l = r_cnt_l;
    assign cmd_cnt_r = r_cnt_r;
    assign overrun   = r_overrun;

endmodule
